// File: rtl/dual_signed_multiplier.sv
// ---------------------------------------------------------------------------
// dual_signed_multiplier
//
// Signed W x W -> 2W multiplier with two independent datapaths that share the
// operands a and b. The combinational path forms W signed partial products
// and reduces them with a pairwise (log-depth) adder tree. The sequential
// path is a radix-2 shift-add engine with a start/done handshake. Both paths
// produce the exact two's-complement product, so their results always match.
//
// Ports:
//   clk          rising-edge clock, sequential path only
//   rst          asynchronous active-high reset, sequential path only
//   start        request a sequential multiply (sampled on clk rising edge)
//   a            signed multiplicand, shared by both paths
//   b            signed multiplier, shared by both paths
//   seq_product  registered signed result of the sequential path
//   done         level: seq_product holds the result of the last request
//   tree_product combinational signed result of the adder tree
// ---------------------------------------------------------------------------
module dual_signed_multiplier #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] seq_product,
   output logic           done,
   output logic [2*W-1:0] tree_product
);

   // Tree geometry: partial products are padded with zeros up to a power of
   // two so every level halves cleanly.
   localparam int LEVELS = (W > 1) ? $clog2(W) : 1;
   localparam int NP     = 1 << LEVELS;

   // Iteration counter must hold the value W itself.
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Combinational path
   // ------------------------------------------------------------------------

   logic [2*W-1:0] a_ext;

   // The multiplicand is sign-extended once to the full result width; all
   // tree arithmetic is then modulo 2^(2W), which is exact because the true
   // product always fits in 2W signed bits.
   assign a_ext = {{W{a[W-1]}}, a};

   // Partial product i is a * b[i] * 2^i. Bit W-1 of b carries weight
   // -2^(W-1), so its partial product is negated instead of added. This
   // keeps the (-2^(W-1))^2 case positive: -(-2^(2W-2)) = +2^(2W-2).
   genvar i;
   generate
      for (i = 0; i < NP; i++) begin : g_pp
         logic [2*W-1:0] pp;
         if (i < W - 1) begin : g_pos
            assign pp = b[i] ? (a_ext << i) : '0;
         end else if (i == W - 1) begin : g_neg
            assign pp = b[i] ? ('0 - (a_ext << i)) : '0;
         end else begin : g_pad
            assign pp = '0;
         end
      end
   endgenerate

   // Pairwise reduction: level 0 holds the partial products, each further
   // level sums adjacent pairs of the level below, and the single node of the
   // last level is the product. Depth is log2(NP) adders.
   genvar l, j;
   generate
      for (l = 0; l <= LEVELS; l++) begin : g_lvl
         logic [2*W-1:0] sum [NP >> l];
         for (j = 0; j < (NP >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
               assign sum[j] = g_pp[j].pp;
            end else begin : g_add
               assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
            end
         end
      end
   endgenerate

   assign tree_product = g_lvl[LEVELS].sum[0];

   // ------------------------------------------------------------------------
   // Sequential path
   // ------------------------------------------------------------------------

   state_t         state;
   state_t         state_next;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] addend;
   logic [CW-1:0]  count;

   // State register. Reset abandons any operation in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. BUSY runs W shift-add steps while the counter is
   // non-zero, then spends one more cycle committing the accumulator to
   // seq_product, which gives a start-to-done latency of W+1 edges. A start
   // seen in DONE restarts immediately, dropping done on the accepting edge;
   // a start seen in BUSY is ignored.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = BUSY;
         BUSY: if (count == '0) state_next = DONE;
         DONE: if (start) state_next = BUSY;
         default: state_next = IDLE;
      endcase
   end

   // Term added to the accumulator this step. The final step (counter == 1)
   // sees the multiplier sign bit and therefore subtracts.
   always_comb begin
      addend = '0;
      if (mplier[0]) begin
         addend = (count == CW'(1)) ? ('0 - mcand) : mcand;
      end
   end

   // Datapath registers. Operands are captured on the accepting edge so later
   // changes on a/b cannot disturb the running operation. seq_product only
   // changes on the transition into DONE (or on reset), so it keeps the last
   // result throughout BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         count       <= '0;
         seq_product <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mcand  <= a_ext;
                  mplier <= b;
                  acc    <= '0;
                  count  <= CW'(W);
               end
            end
            BUSY: begin
               if (count != '0) begin
                  acc    <= acc + addend;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count - CW'(1);
               end else begin
                  seq_product <= acc;
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

   // done is decoded from the registered state, so it is a clean level.
   assign done = (state == DONE);

endmodule

// File: tb/tb_dual_signed_multiplier.sv
// ---------------------------------------------------------------------------
// tb_dual_signed_multiplier
//
// Self-checking bench for dual_signed_multiplier (W = 32). Expected products
// come from plain 64-bit signed multiplication of the operands; expected
// latency is W+1 edges from the accepting edge. Inputs are driven on the
// falling edge and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_dual_signed_multiplier;

   localparam int W = 32;
   localparam int LATENCY = W + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] seq_product;
   logic           done;
   logic [2*W-1:0] tree_product;

   int total  = 0;
   int passed = 0;

   // What seq_product / done are expected to hold between operations.
   logic [2*W-1:0] last_seq = '0;
   logic           exp_done = 1'b0;

   dual_signed_multiplier #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .b            (b),
      .seq_product  (seq_product),
      .done         (done),
      .tree_product (tree_product)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Reference model: exact signed product computed with 64-bit arithmetic.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      longint px;
      longint py;
      px = longint'($signed(x));
      py = longint'($signed(y));
      return px * py;
   endfunction

   // Drive operands with start for one edge; returns 1 ns after that edge.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done, bounded so a stuck design cannot hang the run.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   // Full operation with inline checks on handshake, hold, latency, results.
   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [2*W-1:0] exp;
      int cycles;
      exp = ref_mul(av, bv);
      total++;
      if (done !== exp_done) $display("[TB] FAIL %s pre_done: got %0b expected %0b", name, done, exp_done);
      else passed++;
      applyStimulus(av, bv);
      total++;
      if (tree_product !== exp) $display("[TB] FAIL %s tree: got %0d expected %0d", name, $signed(tree_product), $signed(exp));
      else passed++;
      total++;
      if (done !== 1'b0) $display("[TB] FAIL %s done_drop: got %0b expected 0", name, done);
      else passed++;
      total++;
      if (seq_product !== last_seq) $display("[TB] FAIL %s seq_hold: got %0d expected %0d", name, $signed(seq_product), $signed(last_seq));
      else passed++;
      wait_done(cycles);
      total++;
      if (cycles != LATENCY) $display("[TB] FAIL %s latency: got %0d expected %0d", name, cycles, LATENCY);
      else passed++;
      total++;
      if (seq_product !== exp) $display("[TB] FAIL %s seq: got %0d expected %0d", name, $signed(seq_product), $signed(exp));
      else passed++;
      last_seq = exp;
      exp_done = 1'b1;
   endtask

   // Reset holds the sequential path cleared; the tree ignores reset.
   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 32'd5;
      b     = 32'd7;
      #20;
      total++;
      if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", done);
      else passed++;
      total++;
      if (seq_product !== '0) $display("[TB] FAIL reset_seq: got %0d expected 0", seq_product);
      else passed++;
      total++;
      if (tree_product !== 64'd35) $display("[TB] FAIL reset_tree: got %0d expected 35", tree_product);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Directed operands from the basic plan, including a restart from DONE.
   task automatic test_basic();
      run_op("pos_pos", 32'd15, 32'd10);
      run_op("neg_pos", -32'sd25, 32'd12);
      run_op("neg_neg", -32'sd8, -32'sd8);
      run_op("zero", 32'd0, 32'd123);
   endtask

   // Extreme operands: most positive, most negative and mixed.
   task automatic test_corners();
      run_op("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      total++;
      if (seq_product !== 64'd4611686014132420609) $display("[TB] FAIL max_max_const: got %0d expected 4611686014132420609", seq_product);
      else passed++;
      run_op("min_min", 32'h8000_0000, 32'h8000_0000);
      total++;
      if (seq_product !== 64'd4611686018427387904) $display("[TB] FAIL min_min_const: got %0d expected 4611686018427387904", seq_product);
      else passed++;
      run_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF);
      run_op("neg1_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   // Random operands through the full handshake.
   task automatic test_random_seq();
      for (int n = 0; n < 6; n++) begin
         run_op("rand_seq", $urandom, $urandom);
      end
   endtask

   // Many random operands against the combinational tree alone.
   task automatic test_random_tree();
      logic [W-1:0] av;
      logic [W-1:0] bv;
      for (int n = 0; n < 60; n++) begin
         av = $urandom;
         bv = $urandom;
         if (n % 10 == 0) av = 32'h8000_0000;
         if (n % 10 == 5) bv = 32'h8000_0000;
         @(negedge clk);
         a = av;
         b = bv;
         #1;
         total++;
         if (tree_product !== ref_mul(av, bv)) $display("[TB] FAIL rand_tree: a=%h b=%h got %h expected %h", av, bv, tree_product, ref_mul(av, bv));
         else passed++;
      end
   endtask

   // Asynchronous reset 10 cycles into BUSY, then a clean restart.
   task automatic test_reset_mid();
      applyStimulus(32'd1234, -32'sd77);
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) $display("[TB] FAIL mid_busy_done: got %0b expected 0", done);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (done !== 1'b0) $display("[TB] FAIL mid_reset_done: got %0b expected 0", done);
      else passed++;
      total++;
      if (seq_product !== '0) $display("[TB] FAIL mid_reset_seq: got %0d expected 0", seq_product);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      last_seq = '0;
      exp_done = 1'b0;
      run_op("after_reset", -32'sd3001, 32'd4099);
   endtask

   // Operand changes and a start pulse during BUSY must not disturb the run.
   task automatic test_busy_inputs();
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic [W-1:0] nav;
      logic [W-1:0] nbv;
      int cycles;
      int more;
      av  = $urandom;
      bv  = $urandom;
      nav = ~av;
      nbv = bv ^ 32'h5A5A_0001;
      applyStimulus(av, bv);
      repeat (3) @(posedge clk);
      @(negedge clk);
      a     = nav;
      b     = nbv;
      start = 1'b1;
      #1;
      total++;
      if (tree_product !== ref_mul(nav, nbv)) $display("[TB] FAIL live_tree: got %h expected %h", tree_product, ref_mul(nav, nbv));
      else passed++;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cycles = 4;
      wait_done(more);
      cycles += more;
      total++;
      if (cycles != LATENCY) $display("[TB] FAIL busy_latency: got %0d expected %0d", cycles, LATENCY);
      else passed++;
      total++;
      if (seq_product !== ref_mul(av, bv)) $display("[TB] FAIL captured_seq: got %h expected %h", seq_product, ref_mul(av, bv));
      else passed++;
      total++;
      if (tree_product !== ref_mul(nav, nbv)) $display("[TB] FAIL live_tree_end: got %h expected %h", tree_product, ref_mul(nav, nbv));
      else passed++;
      last_seq = ref_mul(av, bv);
      exp_done = 1'b1;
      // done must hold as a level while no new start arrives.
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1 || seq_product !== last_seq) $display("[TB] FAIL done_hold: done=%0b seq=%h expected 1 and %h", done, seq_product, last_seq);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_random_tree();
      test_random_seq();
      test_reset_mid();
      test_busy_inputs();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/dual_signed_multiplier.md
Name: dual_signed_multiplier

Overview:
- Signed W x W -> 2W multiplier block with two independent datapaths sharing operands `a` and `b`.
- Path 1 is a purely combinational partial-product adder tree (`tree_product`).
- Path 2 is a multi-cycle sequential shift-add multiplier with a start/done handshake (`seq_product`, `done`).
- Used as an arithmetic building block and as a cross-check: both paths must always give bit-identical results for the same operands.

Parameters:
- W, 32, operand width in bits; both operands and results are two's complement; W >= 2.

Ports:
- clk  input  1  rising-edge clock; used by the sequential path only.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sequential multiply; sampled on the rising edge of clk.
- a  input  W  signed multiplicand, shared by both paths.
- b  input  W  signed multiplier, shared by both paths.
- seq_product  output  2W  signed result of the sequential path (registered).
- done  output  1  sequential result valid (level).
- tree_product  output  2W  signed result of the combinational tree (combinational).

Behaviour:
- Arithmetic, both paths: exact signed product sign(a)*sign(b) in 2W bits, so no overflow is possible.
  - Corner case: (-2^(W-1)) * (-2^(W-1)) = +2^(2W-2), which must be returned positive.
- Tree path, structure:
  - Generate W signed partial products, using Baugh-Wooley or radix-4 Booth.
  - Reduce them through a log-depth adder tree (pairwise or carry-save/Wallace) to one 2W-bit sum.
- Tree path, timing: no registers, no dependence on clk or rst; output follows a and b after propagation delay.
- Sequential path, state machine IDLE -> BUSY -> DONE:
  - IDLE: done=0. On a clk edge with start=1, capture a and b into internal registers, clear the accumulator, load the iteration counter with W, and go to BUSY.
  - BUSY: each cycle, examine one multiplier bit (LSB first), add the shifted multiplicand, and shift. The MSB step subtracts instead of adds (two's-complement weight), or an equivalent radix-2 Booth recode is used. After exactly W BUSY cycles, write the result to seq_product, set done=1, and go to DONE.
  - DONE: done stays 1 and seq_product holds its value. A new start=1 clears done on that same edge, captures new operands, and goes to BUSY.
- Latency: start sampled at edge k -> done=1 and valid seq_product after edge k+W+1. For W=32 that is 33 edges.
- start while BUSY is ignored; the operation in progress continues.
- Operand changes after capture do not affect the sequential result.
- done is a level signal, not a pulse. It is guaranteed low from the edge that accepts start until the new result is valid, so a consumer that waits on done after issuing start never sees the stale result.
- seq_product updates only on the transition into DONE. It keeps the previous result during BUSY.
- Reset (rst=1, any time, including mid-operation), asynchronous:
  - state=IDLE, done=0, seq_product=0, and all internal registers and the counter cleared.
  - The operation in progress is abandoned.
  - The first edge after rst deasserts may accept start.

Test Plan:
- Reset 20 ns, then a=15, b=10, pulse start one cycle -> tree_product=150 immediately; done rises 33 cycles later with seq_product=150.
- a=-25, b=12 -> both outputs -300. When start is re-issued from DONE, done must drop on the accepting edge.
- a=-8, b=-8 -> 64. Then a=0, b=123 -> 0 on both paths.
- a=b=32'h7FFFFFFF -> 4611686014132420609 on both paths.
- a=b=32'h80000000 -> 4611686018427387904 (positive) on both paths.
- Mid-operation checks:
  - Assert rst 10 cycles into BUSY -> done=0, seq_product=0 at once; a later start gives a correct result.
  - Change a and b during BUSY -> seq_product reflects the captured operands, while tree_product tracks the live inputs.
